// File: rtl/clock_time_setter.sv
`default_nettype none
// ============================================================================
// Module   : clock_time_setter
// Purpose  : Debounced two-button HH:MM:SS editor; captures the live time,
//            edits it field by field and commits it as seconds-of-day.
//            Optional macro AUTO_REPEAT_EN enables inc-button auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module clock_time_setter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode_n,
    input  logic        btn_inc_n,
    input  logic [16:0] cur_seconds,
    output logic        editing,
    output logic [1:0]  field,
    output logic [4:0]  edit_hour,
    output logic [5:0]  edit_min,
    output logic [5:0]  edit_sec,
    output logic        load_valid,
    output logic [16:0] load_seconds
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CAPTURE  = 3'd1;
    localparam logic [2:0] SET_HOUR = 3'd2;
    localparam logic [2:0] SET_MIN  = 3'd3;
    localparam logic [2:0] SET_SEC  = 3'd4;
    localparam logic [2:0] COMMIT   = 3'd5;

    logic [1:0]  raw_n;
    logic [1:0]  press;
    logic [1:0]  level;
    logic        mode_evt;
    logic        inc_evt;
    logic [2:0]  state;
    logic [16:0] remainder;
    logic [16:0] commit_value;

    assign raw_n = {btn_inc_n, btn_mode_n};

    // Bit 0 = mode button, bit 1 = inc button.
    generate
        for (genvar b = 0; b < 2; b++) begin : g_btn
            logic            sync1;
            logic            sync2;
            logic            lvl;
            logic            lvl_d;
            logic            pulse;
            logic [DB_W-1:0] cnt;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    sync1 <= 1'b1;
                    sync2 <= 1'b1;
                    lvl   <= 1'b1;
                    lvl_d <= 1'b1;
                    pulse <= 1'b0;
                    cnt   <= '0;
                end else begin
                    sync1 <= raw_n[b];
                    sync2 <= sync1;
                    lvl_d <= lvl;
                    pulse <= lvl_d & ~lvl;
                    if (sync2 == lvl) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        cnt <= '0;
                        lvl <= sync2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign press[b] = pulse;
            assign level[b] = lvl;
        end
    endgenerate

    assign mode_evt = press[0];

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD);

    logic             in_set;
    logic             rep_active;
    logic             rep_first;
    logic             rep_evt;
    logic [REP_W-1:0] rep_cnt;

    assign in_set  = (state == SET_HOUR) || (state == SET_MIN) || (state == SET_SEC);
    assign rep_evt = rep_active && (rep_cnt == (rep_first ? REP_FIRST : REP_NEXT));

    // rep_cnt holds the number of cycles since the last real or repeated event.
    always_ff @(posedge clk) begin
        if (!reset || !in_set || level[1] || mode_evt) begin
            rep_active <= 1'b0;
            rep_first  <= 1'b0;
            rep_cnt    <= '0;
        end else if (press[1]) begin
            rep_active <= 1'b1;
            rep_first  <= 1'b1;
            rep_cnt    <= REP_W'(1);
        end else if (rep_evt) begin
            rep_first  <= 1'b0;
            rep_cnt    <= REP_W'(1);
        end else if (rep_active) begin
            rep_cnt    <= rep_cnt + 1'b1;
        end
    end

    assign inc_evt = press[1] | rep_evt;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0], level[1]};
    assign inc_evt = press[1];
`endif

    assign commit_value = 17'(edit_hour) * 17'd3600 + 17'(edit_min) * 17'd60 + 17'(edit_sec);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            remainder    <= '0;
            edit_hour    <= '0;
            edit_min     <= '0;
            edit_sec     <= '0;
            load_valid   <= 1'b0;
            load_seconds <= '0;
        end else begin
            load_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (mode_evt) begin
                        remainder <= (cur_seconds >= 17'd86400) ? '0 : cur_seconds;
                        edit_hour <= '0;
                        edit_min  <= '0;
                        edit_sec  <= '0;
                        state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (remainder >= 17'd3600) begin
                        remainder <= remainder - 17'd3600;
                        edit_hour <= edit_hour + 5'd1;
                    end else if (remainder >= 17'd60) begin
                        remainder <= remainder - 17'd60;
                        edit_min  <= edit_min + 6'd1;
                    end else begin
                        edit_sec  <= remainder[5:0];
                        state     <= SET_HOUR;
                    end
                end
                SET_HOUR: begin
                    if (mode_evt)     state     <= SET_MIN;
                    else if (inc_evt) edit_hour <= (edit_hour == 5'd23) ? '0 : edit_hour + 5'd1;
                end
                SET_MIN: begin
                    if (mode_evt)     state    <= SET_SEC;
                    else if (inc_evt) edit_min <= (edit_min == 6'd59) ? '0 : edit_min + 6'd1;
                end
                SET_SEC: begin
                    if (mode_evt) begin
                        state        <= COMMIT;
                        load_valid   <= 1'b1;
                        load_seconds <= commit_value;
                    end else if (inc_evt) begin
                        edit_sec <= (edit_sec == 6'd59) ? '0 : edit_sec + 6'd1;
                    end
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign editing = (state != IDLE);

    always_comb begin
        field = 2'd0;
        case (state)
            SET_HOUR: field = 2'd1;
            SET_MIN:  field = 2'd2;
            SET_SEC:  field = 2'd3;
            default:  field = 2'd0;
        endcase
    end

endmodule
`default_nettype wire
